// File: rtl/mem_port_arbiter.sv
// Arbitrates a single-ported, LATENCY-cycle memory between instruction (I) and data (D) requesters.
// Define MEM_ARB_RR_EN for round-robin grant on simultaneous requests; default is D-over-I priority.
module mem_port_arbiter #(
    parameter int unsigned WORD_SIZE = 16,
    parameter int unsigned LATENCY   = 4
) (
    input  logic                 Clk,
    input  logic                 Reset_N,
    input  logic                 i_req,
    input  logic [WORD_SIZE-1:0] i_addr,
    output logic                 i_done,
    output logic [WORD_SIZE-1:0] i_rdata,
    input  logic                 d_req,
    input  logic                 d_we,
    input  logic [WORD_SIZE-1:0] d_addr,
    input  logic [WORD_SIZE-1:0] d_wdata,
    output logic                 d_done,
    output logic [WORD_SIZE-1:0] d_rdata,
    output logic                 mem_read,
    output logic                 mem_write,
    output logic [WORD_SIZE-1:0] mem_addr,
    output logic [WORD_SIZE-1:0] mem_wdata,
    input  logic [WORD_SIZE-1:0] mem_rdata,
    output logic                 busy
);

    typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

    localparam logic [7:0] CntLoad = 8'(LATENCY - 1);

    state_e               state_q, state_d;
    logic [7:0]           cnt_q;
    logic                 win_d_q;   // 1 = D side owns the current transaction
    logic                 we_q;
    logic [WORD_SIZE-1:0] addr_q;
    logic [WORD_SIZE-1:0] wdata_q;
    logic [WORD_SIZE-1:0] i_rdata_q;
    logic [WORD_SIZE-1:0] d_rdata_q;
    logic                 any_req;
    logic                 grant_d;

    assign any_req = i_req | d_req;

`ifdef MEM_ARB_RR_EN
    logic last_win_d_q;

    // On a tie, favour the side that did not win the previous grant.
    assign grant_d = (i_req && d_req) ? ~last_win_d_q : d_req;

    always_ff @(posedge Clk or negedge Reset_N) begin
        if (!Reset_N) begin
            last_win_d_q <= 1'b0;
        end else if (state_q == StIdle && any_req) begin
            last_win_d_q <= grant_d;
        end
    end
`else
    assign grant_d = d_req;
`endif

    always_ff @(posedge Clk or negedge Reset_N) begin
        if (!Reset_N) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (any_req) state_d = StBusy;
            StBusy: if (cnt_q == 8'd0) state_d = StResp;
            StResp: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_N) begin
        if (!Reset_N) begin
            cnt_q     <= 8'd0;
            win_d_q   <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (any_req) begin
                        win_d_q <= grant_d;
                        we_q    <= grant_d & d_we;
                        addr_q  <= grant_d ? d_addr : i_addr;
                        wdata_q <= grant_d ? d_wdata : '0;
                        cnt_q   <= CntLoad;
                    end
                end
                StBusy: begin
                    if (cnt_q == 8'd0) begin
                        if (!we_q) begin
                            if (win_d_q) d_rdata_q <= mem_rdata;
                            else         i_rdata_q <= mem_rdata;
                        end
                    end else begin
                        cnt_q <= cnt_q - 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs decode straight from registers so reset drops strobes immediately.
    assign busy      = (state_q != StIdle);
    assign mem_read  = (state_q == StBusy) & ~we_q;
    assign mem_write = (state_q == StBusy) & we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign i_done    = (state_q == StResp) & ~win_d_q;
    assign d_done    = (state_q == StResp) & win_d_q;
    assign i_rdata   = i_rdata_q;
    assign d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter in its default (fixed-priority) build.
module tb_mem_port_arbiter;

    localparam int unsigned W = 16;
    localparam int unsigned L = 4;

    logic         Clk;
    logic         Reset_N;
    logic         i_req;
    logic [W-1:0] i_addr;
    logic         i_done;
    logic [W-1:0] i_rdata;
    logic         d_req;
    logic         d_we;
    logic [W-1:0] d_addr;
    logic [W-1:0] d_wdata;
    logic         d_done;
    logic [W-1:0] d_rdata;
    logic         mem_read;
    logic         mem_write;
    logic [W-1:0] mem_addr;
    logic [W-1:0] mem_wdata;
    logic [W-1:0] mem_rdata;
    logic         busy;

    int checks = 0;
    int errors = 0;
    int n;

    mem_port_arbiter #(.WORD_SIZE(W), .LATENCY(L)) dut (
        .Clk       (Clk),
        .Reset_N   (Reset_N),
        .i_req     (i_req),
        .i_addr    (i_addr),
        .i_done    (i_done),
        .i_rdata   (i_rdata),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_done    (d_done),
        .d_rdata   (d_rdata),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .busy      (busy)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chkb(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
        end
    endtask

    initial begin
        Reset_N   = 1'b0;
        i_req     = 1'b0;
        i_addr    = '0;
        d_req     = 1'b0;
        d_we      = 1'b0;
        d_addr    = '0;
        d_wdata   = '0;
        mem_rdata = '0;

        // Reset state
        #12;
        chkb("rst_busy", busy, 1'b0);
        chkb("rst_mem_read", mem_read, 1'b0);
        chkb("rst_mem_write", mem_write, 1'b0);
        chkb("rst_i_done", i_done, 1'b0);
        chkb("rst_d_done", d_done, 1'b0);
        chk("rst_mem_addr", mem_addr, 16'h0000);
        chk("rst_i_rdata", i_rdata, 16'h0000);
        chk("rst_d_rdata", d_rdata, 16'h0000);
        Reset_N = 1'b1;
        tick();
        chkb("idle_busy", busy, 1'b0);

        // Single I read
        i_req = 1'b1; i_addr = 16'h0010; mem_rdata = 16'hABCD;
        tick();
        for (int k = 0; k < int'(L); k++) begin
            chkb("t1_mem_read", mem_read, 1'b1);
            chkb("t1_mem_write", mem_write, 1'b0);
            chk("t1_mem_addr", mem_addr, 16'h0010);
            chkb("t1_i_done_early", i_done, 1'b0);
            tick();
        end
        chkb("t1_i_done", i_done, 1'b1);
        chkb("t1_d_done", d_done, 1'b0);
        chk("t1_i_rdata", i_rdata, 16'hABCD);
        chkb("t1_resp_read", mem_read, 1'b0);
        i_req = 1'b0;
        tick();
        chkb("t1_done_clear", i_done, 1'b0);
        chkb("t1_idle", busy, 1'b0);

        // D write; d_rdata must not change
        d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0020; d_wdata = 16'h1234; mem_rdata = 16'h5555;
        tick();
        for (int k = 0; k < int'(L); k++) begin
            chkb("t2_mem_write", mem_write, 1'b1);
            chkb("t2_mem_read", mem_read, 1'b0);
            chk("t2_mem_addr", mem_addr, 16'h0020);
            chk("t2_mem_wdata", mem_wdata, 16'h1234);
            tick();
        end
        chkb("t2_d_done", d_done, 1'b1);
        chkb("t2_i_done", i_done, 1'b0);
        chkb("t2_resp_write", mem_write, 1'b0);
        chk("t2_d_rdata", d_rdata, 16'h0000);
        d_req = 1'b0; d_we = 1'b0;
        tick();
        chkb("t2_done_clear", d_done, 1'b0);

        // Simultaneous requests: D first, then I LATENCY+2 cycles later
        i_req = 1'b1; i_addr = 16'h0060;
        d_req = 1'b1; d_addr = 16'h0030; mem_rdata = 16'h3333;
        tick();
        chk("t3_d_addr", mem_addr, 16'h0030);
        chkb("t3_d_read", mem_read, 1'b1);
        for (int k = 1; k < int'(L); k++) tick();
        chk("t3_d_addr_last", mem_addr, 16'h0030);
        tick();
        chkb("t3_d_done", d_done, 1'b1);
        chkb("t3_i_done_excl", i_done, 1'b0);
        chk("t3_d_rdata", d_rdata, 16'h3333);
        d_req = 1'b0; mem_rdata = 16'h6666;
        n = 0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (k == 2) chk("t3_i_addr", mem_addr, 16'h0060);
            if (i_done) begin
                n = k;
                break;
            end
        end
        chk("t3_i_spacing", 16'(n), 16'(L + 2));
        chk("t3_i_rdata", i_rdata, 16'h6666);
        chk("t3_d_rdata_hold", d_rdata, 16'h3333);
        i_req = 1'b0;
        tick();

        // Address stability during BUSY
        i_req = 1'b1; i_addr = 16'h0040; mem_rdata = 16'h4444;
        tick();
        i_addr = 16'h0050;
        for (int k = 0; k < int'(L); k++) begin
            chk("t4_mem_addr", mem_addr, 16'h0040);
            tick();
        end
        chkb("t4_i_done", i_done, 1'b1);
        chk("t4_resp_addr", mem_addr, 16'h0040);
        i_req = 1'b0;
        tick();

        // Reset on 2nd BUSY cycle aborts with no done
        i_req = 1'b1; i_addr = 16'h0070;
        tick();
        tick();
        chkb("t5_read_before", mem_read, 1'b1);
        #2 Reset_N = 1'b0;
        #1;
        chkb("t5_read_drop", mem_read, 1'b0);
        chkb("t5_busy_drop", busy, 1'b0);
        chk("t5_addr_zero", mem_addr, 16'h0000);
        chk("t5_i_rdata_zero", i_rdata, 16'h0000);
        i_req = 1'b0;
        tick();
        tick();
        chkb("t5_no_done", i_done, 1'b0);
        #3 Reset_N = 1'b1;
        tick();
        chkb("t5_post_done", i_done, 1'b0);
        chkb("t5_post_busy", busy, 1'b0);
        i_req = 1'b1; i_addr = 16'h0080; mem_rdata = 16'hBEEF;
        n = 0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (i_done) begin
                n = k;
                break;
            end
        end
        chk("t5_fresh_latency", 16'(n), 16'(L + 1));
        chk("t5_fresh_rdata", i_rdata, 16'hBEEF);
        i_req = 1'b0;
        tick();
        chkb("t5_final_idle", busy, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
